// File: rtl/fd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fd_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Decides, every
//   cycle, whether the PC holds, whether the IF/D register stalls or loads a
//   NOP, whether the D/X register gets a bubble, and whether the whole back
//   end freezes. Handles load-use hazards, branch/jump redirects, memory
//   waits and HALT. A saturating counter of PC-hold cycles aids perf debug.
//
// Parameters
//   REG_W        register-specifier width
//   FLUSH_DEPTH  cycles IF/D is flushed after a redirect (1..3)
//   CNT_W        width of stall_cnt
//
// Ports
//   clk          system clock, all state on rising edge
//   rst_n        synchronous reset, active-low
//   d_rs, d_rt   decode-stage source registers
//   d_use_rs/rt  decode instruction actually reads d_rs / d_rt
//   d_halt       decode instruction is HALT
//   x_memrd      instruction in X is a load
//   x_rd         destination register of instruction in X
//   x_redirect   branch/jump resolved in X, PC redirected this cycle
//   imem_busy    fetch memory not ready
//   dmem_busy    data memory not ready (freeze whole pipe)
//   imem_err     fetch memory error
//   pc_hold      PC keeps its value
//   fd_stall     IF/D register holds
//   fd_flush     IF/D register loads NOP
//   dx_flush     D/X register loads a bubble
//   pipe_freeze  all later pipeline registers hold
//   halted       pipeline halted
//   err          sticky fetch error
//   stall_cnt    saturating count of cycles with pc_hold=1 (not while halted)
// -----------------------------------------------------------------------------
module fd_hazard_ctrl #(
  parameter int REG_W       = 3,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_halt,
  input  logic             x_memrd,
  input  logic [REG_W-1:0] x_rd,
  input  logic             x_redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             imem_err,
  output logic             pc_hold,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REDIR,
    ST_HALTED
  } state_t;

  // Extra flush cycles owed after the redirect cycle itself.
  localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state, state_nxt;
  logic [1:0]       flush_cnt, flush_cnt_nxt;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use_hit;

  // A load in X whose destination feeds a register the decode instruction
  // really reads: the loaded value is not ready yet, so decode must wait.
  always_comb begin
    load_use_hit = x_memrd &&
                   ((d_use_rs && (d_rs == x_rd)) ||
                    (d_use_rt && (d_rt == x_rd)));
  end

  // Next-state and output decode. Priority inside RUN is encoded by the
  // if/else chain order; a frozen data memory beats everything because
  // nothing downstream may move. While reset is held, IF/D loads a NOP so
  // decode never sees stale instructions (in particular not a HALT).
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_hold       = 1'b0;
    fd_stall      = 1'b0;
    fd_flush      = 1'b0;
    dx_flush      = 1'b0;
    pipe_freeze   = 1'b0;
    halted        = 1'b0;

    case (state)
      ST_RUN: begin
        if (dmem_busy) begin
          pipe_freeze = 1'b1;
          pc_hold     = 1'b1;
          fd_stall    = 1'b1;
        end else if (x_redirect) begin
          // Wrong-path instructions in F and D are squashed; any hazard or
          // HALT seen in decode belongs to the wrong path and is dropped.
          fd_flush = 1'b1;
          dx_flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_nxt     = ST_REDIR;
            flush_cnt_nxt = FLUSH_RELOAD;
          end
        end else if (load_use_hit) begin
          pc_hold  = 1'b1;
          fd_stall = 1'b1;
          dx_flush = 1'b1;
        end else if (d_halt) begin
          pc_hold   = 1'b1;
          fd_stall  = 1'b1;
          state_nxt = ST_HALTED;
        end else if (imem_busy) begin
          pc_hold  = 1'b1;
          fd_flush = 1'b1;
        end
      end

      ST_REDIR: begin
        if (dmem_busy) begin
          pipe_freeze = 1'b1;
          pc_hold     = 1'b1;
          fd_stall    = 1'b1;
        end else begin
          fd_flush = 1'b1;
          if (x_redirect) begin
            flush_cnt_nxt = FLUSH_RELOAD;
          end else if (flush_cnt <= 2'd1) begin
            flush_cnt_nxt = 2'd0;
            state_nxt     = ST_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 2'd1;
          end
        end
      end

      ST_HALTED: begin
        pc_hold  = 1'b1;
        fd_stall = 1'b1;
        halted   = 1'b1;
        dx_flush = 1'b1;
      end

      default: begin
        state_nxt     = ST_RUN;
        flush_cnt_nxt = 2'd0;
      end
    endcase

    if (!rst_n) begin
      pc_hold     = 1'b0;
      fd_stall    = 1'b0;
      fd_flush    = 1'b1;
      dx_flush    = 1'b0;
      pipe_freeze = 1'b0;
      halted      = 1'b0;
    end
  end

  // State, sticky error and the saturating stall counter. The counter
  // ignores halted cycles so a parked core does not swamp the statistic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (imem_err) begin
        err_q <= 1'b1;
      end
      if (pc_hold && (state != ST_HALTED) && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Registered outputs read as zero while reset is asserted.
  assign err       = rst_n ? err_q : 1'b0;
  assign stall_cnt = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_fd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fd_hazard_ctrl
//   Bench for fd_hazard_ctrl (FLUSH_DEPTH=2, CNT_W=2). A stimulus process
//   drives directed scenarios then random traffic; for every driven cycle a
//   reference model computes the expected outputs and pushes them into a
//   queue. A monitor process pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_fd_hazard_ctrl;

  localparam int REG_W       = 3;
  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 2;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [2:0] d_rs;
    logic [2:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic       d_halt;
    logic       x_memrd;
    logic [2:0] x_rd;
    logic       x_redirect;
    logic       imem_busy;
    logic       dmem_busy;
    logic       imem_err;
  } stim_t;

  // Expected/actual bundle: {pc_hold, fd_stall, fd_flush, dx_flush,
  // pipe_freeze, halted, err, stall_cnt[1:0]}
  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [REG_W-1:0] d_rs, d_rt, x_rd;
  logic             d_use_rs, d_use_rt, d_halt, x_memrd;
  logic             x_redirect, imem_busy, dmem_busy, imem_err;
  logic             pc_hold, fd_stall, fd_flush, dx_flush;
  logic             pipe_freeze, halted, err;
  logic [CNT_W-1:0] stall_cnt;

  int   tests_run = 0;
  int   failures  = 0;
  int   cyc_no    = 0;
  exp_t exp_q[$];

  // Reference model state, kept in spec terms: are we parked on a HALT,
  // how many redirect flush cycles are still owed, how many stall cycles
  // have been seen, and has a fetch error ever occurred.
  bit halted_m;
  int flush_owed;
  int stalls_m;
  bit err_m;

  fd_hazard_ctrl #(
    .REG_W(REG_W),
    .FLUSH_DEPTH(FLUSH_DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .d_rs(d_rs),
    .d_rt(d_rt),
    .d_use_rs(d_use_rs),
    .d_use_rt(d_use_rt),
    .d_halt(d_halt),
    .x_memrd(x_memrd),
    .x_rd(x_rd),
    .x_redirect(x_redirect),
    .imem_busy(imem_busy),
    .dmem_busy(dmem_busy),
    .imem_err(imem_err),
    .pc_hold(pc_hold),
    .fd_stall(fd_stall),
    .fd_flush(fd_flush),
    .dx_flush(dx_flush),
    .pipe_freeze(pipe_freeze),
    .halted(halted),
    .err(err),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t idle();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Expected outputs for the current model state and these inputs.
  function automatic logic [8:0] modelOut(stim_t s);
    logic ph, fs, ff, df, pf, hl, hit;
    ph = 0; fs = 0; ff = 0; df = 0; pf = 0; hl = 0;
    if (!s.rst_n) return 9'b0010_0000_0;
    hit = s.x_memrd && ((s.d_use_rs && s.d_rs == s.x_rd) ||
                        (s.d_use_rt && s.d_rt == s.x_rd));
    if (halted_m) begin
      ph = 1; fs = 1; hl = 1; df = 1;
    end else if (s.dmem_busy) begin
      pf = 1; ph = 1; fs = 1;
    end else if (flush_owed > 0) begin
      ff = 1;
    end else if (s.x_redirect) begin
      ff = 1; df = 1;
    end else if (hit) begin
      ph = 1; fs = 1; df = 1;
    end else if (s.d_halt) begin
      ph = 1; fs = 1;
    end else if (s.imem_busy) begin
      ph = 1; ff = 1;
    end
    return {ph, fs, ff, df, pf, hl, err_m, 2'(stalls_m)};
  endfunction

  // Advance the model by one clock edge.
  function automatic void modelAdvance(stim_t s, logic ph);
    logic hit;
    if (!s.rst_n) begin
      halted_m = 0; flush_owed = 0; stalls_m = 0; err_m = 0;
      return;
    end
    hit = s.x_memrd && ((s.d_use_rs && s.d_rs == s.x_rd) ||
                        (s.d_use_rt && s.d_rt == s.x_rd));
    if (s.imem_err) err_m = 1;
    if (ph && !halted_m && stalls_m < CNT_SAT) stalls_m++;
    if (halted_m || s.dmem_busy) return;
    if (flush_owed > 0) begin
      if (s.x_redirect) flush_owed = FLUSH_DEPTH - 1;
      else              flush_owed--;
    end else if (s.x_redirect) begin
      flush_owed = FLUSH_DEPTH - 1;
    end else if (!hit && s.d_halt) begin
      halted_m = 1;
    end
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // response the model expects to see before the next rising edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = s.rst_n;
    d_rs       = s.d_rs;
    d_rt       = s.d_rt;
    d_use_rs   = s.d_use_rs;
    d_use_rt   = s.d_use_rt;
    d_halt     = s.d_halt;
    x_memrd    = s.x_memrd;
    x_rd       = s.x_rd;
    x_redirect = s.x_redirect;
    imem_busy  = s.imem_busy;
    dmem_busy  = s.dmem_busy;
    imem_err   = s.imem_err;
    e.cyc      = cyc_no;
    e.v        = modelOut(s);
    exp_q.push_back(e);
    modelAdvance(s, e.v[8]);
    cyc_no++;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] act,
                             input logic [8:0] expv);
    tests_run++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b (ph fs ff df pf hl err cnt)",
               name, act, expv);
    end
  endtask

  // Monitor: compare the DUT against each queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("cycle %0d", e.cyc),
                    {pc_hold, fd_stall, fd_flush, dx_flush, pipe_freeze,
                     halted, err, stall_cnt}, e.v);
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cnt;
    rst_n = 0; d_rs = 0; d_rt = 0; x_rd = 0;
    d_use_rs = 0; d_use_rt = 0; d_halt = 0; x_memrd = 0;
    x_redirect = 0; imem_busy = 0; dmem_busy = 0; imem_err = 0;
    halted_m = 0; flush_owed = 0; stalls_m = 0; err_m = 0;

    // Reset held two cycles, then release.
    s = idle(); s.rst_n = 0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());

    // Load-use hit on rs for one cycle, then clear.
    s = idle(); s.x_memrd = 1; s.x_rd = 3; s.d_use_rs = 1; s.d_rs = 3;
    applyStimulus(s);
    applyStimulus(idle());

    // Redirect together with a load-use hit, then the owed flush cycle.
    s = idle(); s.rst_n = 0;
    applyStimulus(s);
    s = idle(); s.x_redirect = 1; s.x_memrd = 1; s.x_rd = 5;
    s.d_use_rt = 1; s.d_rt = 5;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());

    // Data memory stall for three cycles in the middle of a redirect.
    s = idle(); s.x_redirect = 1;
    applyStimulus(s);
    s = idle(); s.dmem_busy = 1;
    repeat (3) applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());

    // HALT, stay parked, then reset back to running.
    s = idle(); s.rst_n = 0;
    applyStimulus(s);
    s = idle(); s.imem_busy = 1;
    applyStimulus(s);
    s = idle(); s.d_halt = 1;
    applyStimulus(s);
    repeat (10) applyStimulus(idle());
    s = idle(); s.rst_n = 0;
    applyStimulus(s);
    applyStimulus(idle());

    // Fetch error pulse with a four-cycle fetch wait; counter saturates.
    s = idle(); s.imem_err = 1; s.imem_busy = 1;
    applyStimulus(s);
    s = idle(); s.imem_busy = 1;
    repeat (3) applyStimulus(s);
    repeat (2) applyStimulus(idle());

    // Random traffic with hazards biased to occur often.
    for (int i = 0; i < 3000; i++) begin
      s            = '0;
      s.rst_n      = 1'($urandom_range(0, 99) >= 4);
      s.x_rd       = 3'($urandom_range(0, 7));
      s.d_rs       = ($urandom_range(0, 2) == 0) ? s.x_rd : 3'($urandom_range(0, 7));
      s.d_rt       = ($urandom_range(0, 2) == 0) ? s.x_rd : 3'($urandom_range(0, 7));
      s.d_use_rs   = 1'($urandom_range(0, 1));
      s.d_use_rt   = 1'($urandom_range(0, 1));
      s.x_memrd    = 1'($urandom_range(0, 99) < 40);
      s.d_halt     = 1'($urandom_range(0, 99) < 5);
      s.x_redirect = 1'($urandom_range(0, 99) < 15);
      s.imem_busy  = 1'($urandom_range(0, 99) < 20);
      s.dmem_busy  = 1'($urandom_range(0, 99) < 15);
      s.imem_err   = 1'($urandom_range(0, 99) < 3);
      applyStimulus(s);
    end

    // Let the monitor drain the queue, with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
